// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Holds the op encodings, FSM states and operand-sign helpers.
package muldiv_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_mop(
        input logic [6:0] opcode,
        input logic [6:0] funct7
    );
        return (opcode == OPC_RTYPE) && (funct7 == F7_MULDIV);
    endfunction

    function automatic logic signed_a(input funct3_e f);
        return (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic signed_b(input funct3_e f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negate of a W-bit value.
// Used as abs() on operands and as the final sign fix-up.
module muldiv_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // negate when requested, otherwise pass through
    always_comb begin
        res = neg ? (~val + W'(1)) : val;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One shift-add or shift-subtract step per cycle, XLEN steps per op.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state, state_nxt;
    logic [CW-1:0]     cnt;
    funct3_e           op_q;
    logic [XLEN-1:0]   b_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;

    funct3_e           f3;
    logic              sgn_a, sgn_b, neg_start;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special, accept;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted, diff;
    logic [2*XLEN-1:0] mul_step, div_step, acc_step;
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   calc_res;

    assign f3     = funct3_e'(funct3);
    assign sgn_a  = signed_a(f3) & opa[XLEN-1];
    assign sgn_b  = signed_b(f3) & opb[XLEN-1];
    assign accept = start & ~flush;

    // REM takes the dividend's sign; others negate when signs differ
    assign neg_start = (funct3[2] & funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);

    muldiv_sign #(.W(XLEN)) u_abs_a (
        .val (opa),
        .neg (sgn_a),
        .res (a_mag)
    );

    muldiv_sign #(.W(XLEN)) u_abs_b (
        .val (opb),
        .neg (sgn_b),
        .res (b_mag)
    );

    assign div_zero = funct3[2] & (opb == '0);
    assign div_ovf  = ((f3 == F3_DIV) || (f3 == F3_REM)) &
                      (opa == SMIN) & (opb == '1);
    assign special  = div_zero | div_ovf;

    // results for ops that finish without iterating
    always_comb begin
        special_res = '0;
        unique case (1'b1)
            div_zero & ~funct3[1]: special_res = '1;
            div_zero &  funct3[1]: special_res = opa;
            div_ovf  & ~funct3[1]: special_res = SMIN;
            div_ovf  &  funct3[1]: special_res = '0;
            default:               special_res = '0;
        endcase
    end

    // one shift-add (mul) or restoring shift-subtract (div) step
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mul_step = acc[0] ? {add_sum, acc[XLEN-1:1]}
                          : {1'b0, acc[2*XLEN-1:1]};
        shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = shifted - {1'b0, b_q};
        div_step = diff[XLEN]
                 ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                 : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_step = op_q[2] ? div_step : mul_step;
    end

    // pick product, quotient or remainder for the sign fix-up
    always_comb begin
        fix_in = acc_step;
        if (op_q[2]) begin
            fix_in = op_q[1]
                   ? {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]}
                   : {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
        end
    end

    muldiv_sign #(.W(2*XLEN)) u_fix (
        .val (fix_in),
        .neg (neg_q),
        .res (fix_out)
    );

    assign calc_res = ((op_q == F3_MUL) || op_q[2])
                    ? fix_out[XLEN-1:0]
                    : fix_out[2*XLEN-1:XLEN];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)            state_nxt = S_IDLE;
                else if (cnt == '0)   state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: hold the pipeline, flag the result cycle
    always_comb begin
        stall = ((state == S_IDLE) & start) | (state == S_CALC);
        done  = (state == S_DONE) & ~flush;
    end

    // operand latch, iteration datapath, counter and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= F3_MUL;
            b_q    <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept && special) begin
                        result <= special_res;
                    end else if (accept) begin
                        cnt   <= CNT_LAST;
                        op_q  <= f3;
                        b_q   <= b_mag;
                        neg_q <= neg_start;
                        acc   <= {{XLEN{1'b0}}, a_mag};
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        acc <= acc_step;
                        if (cnt == '0) result <= calc_res;
                        else           cnt    <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq.
// Table of ops plus flush, reset and back-to-back sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opa, opb;
    logic        flush;
    logic        stall, done;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .opa    (opa),
        .opb    (opb),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int stl);
        @(posedge clk);
        #1;
        check("idle_done", {31'b0, done}, 32'd0);
        start  = 1'b1;
        funct3 = f;
        opa    = a;
        opb    = b;
        lat    = 0;
        stl    = 0;
        #1;
        if (stall) stl++;
        @(posedge clk);
        #1;
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        lat   = 1;
        while (!done && lat < 100) begin
            if (stall) stl++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_on_done", {31'b0, stall}, 32'd0);
        res = result;
    endtask

    logic [31:0] r;
    int          lat, stl;
    int          seen;

    initial begin
        vecs[0]  = '{"mul_7_m3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{"mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[2]  = '{"mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[3]  = '{"mulhsu_m1",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[4]  = '{"div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{"rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{"divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{"remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{"divu_by0",    3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{"rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[11] = '{"rem_by0",     3'b110, 32'h1234,     32'd0,        32'h00001234, 1};

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        opa    = '0;
        opb    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",  {31'b0, stall}, 32'd0);
        check("rst_done",   {31'b0, done},  32'd0);
        check("rst_result", result,         32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, r, lat, stl);
            check({vecs[i].name, "_res"}, r, vecs[i].exp);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_stall"}, stl, (vecs[i].lat == 1) ? 1 : 33);
        end

        // flush in the 10th CALC cycle; result keeps 0x1234
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = 3'b000;
        opa    = 32'h0000ABCD;
        opb    = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_pre_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_stall",  {31'b0, stall}, 32'd0);
        check("flush_done",   {31'b0, done},  32'd0);
        check("flush_result", result,         32'h00001234);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("flush_no_done", seen, 0);
        check("flush_hold", result, 32'h00001234);
        run_op(3'b000, 32'd3, 32'd4, r, lat, stl);
        check("post_flush_res", r, 32'd12);
        check("post_flush_lat", lat, 33);

        // synchronous reset in the middle of CALC
        @(posedge clk);
        #1;
        start  = 1'b1;
        funct3 = 3'b000;
        opa    = 32'd9;
        opb    = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_stall",  {31'b0, stall}, 32'd0);
        check("midrst_done",   {31'b0, done},  32'd0);
        check("midrst_result", result,         32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);

        // back-to-back multiplies
        run_op(3'b000, 32'd2, 32'd3, r, lat, stl);
        check("b2b_first_res", r, 32'd6);
        check("b2b_first_lat", lat, 33);
        run_op(3'b000, 32'd5, 32'd5, r, lat, stl);
        check("b2b_second_res", r, 32'd25);
        check("b2b_second_lat", lat, 33);
        @(posedge clk);
        #1;
        check("b2b_done_pulse", {31'b0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
